regfile_mp_sb: RTL

- Parametrised multi-port general-purpose register file for the RISC-V core; successor to the single-write, two-read file.
- Provides NUM_RD asynchronous read ports and two synchronous write ports (W0 = ALU writeback, W1 = load/CSR writeback).
- Adds a per-register busy scoreboard for hazard detection.
- Register 0 is hardwired to zero and is never busy.

---
 rtl/regfile_mp_sb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file: NUM_RD async read ports, two write ports (W1 beats W0), busy scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.

module regfile_mp_sb_rdport #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic [DEPTH-1:0][DATA_W-1:0] regs_i,
   input  logic [DEPTH-1:0]             busy_i,
   input  logic [ADDR_W-1:0]            addr_i,
`ifdef REGFILE_BYPASS_EN
   input  logic                         rst_ni,
   input  logic [1:0]                   wen_i,
   input  logic [1:0][ADDR_W-1:0]       waddr_i,
   input  logic [1:0][DATA_W-1:0]       wdata_i,
   input  logic                         iss_en_i,
   input  logic [ADDR_W-1:0]            iss_addr_i,
`endif
   output logic [DATA_W-1:0]            data_o,
   output logic                         busy_o
);

`ifdef REGFILE_BYPASS_EN
   logic hit0, hit1, iss_hit;

   // Forwarding is suppressed under reset so held-off writes never leak to the read side.
   assign hit1    = rst_ni && wen_i[1] && (waddr_i[1] == addr_i) && (addr_i != '0);
   assign hit0    = rst_ni && wen_i[0] && (waddr_i[0] == addr_i) && (addr_i != '0);
   assign iss_hit = iss_en_i && (iss_addr_i == addr_i);

   always_comb begin
      data_o = regs_i[addr_i];
      if (hit1)      data_o = wdata_i[1];
      else if (hit0) data_o = wdata_i[0];
   end

   assign busy_o = busy_i[addr_i] && !((hit0 || hit1) && !iss_hit);
`else
   assign data_o = regs_i[addr_i];
   assign busy_o = busy_i[addr_i];
`endif

endmodule

module regfile_mp_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     w0_en,
   input  logic [ADDR_W-1:0]        w0_addr,
   input  logic [DATA_W-1:0]        w0_data,
   input  logic                     w1_en,
   input  logic [ADDR_W-1:0]        w1_addr,
   input  logic [DATA_W-1:0]        w1_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     any_busy
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   wr_req_t [1:0]                wr;
   logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]             busy_q, busy_d;

   assign wr[0] = {w0_en, w0_addr, w0_data};
   assign wr[1] = {w1_en, w1_addr, w1_data};

   // Port order gives W1 priority; issue applied last so a new producer beats a retiring one.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int p = 0; p < 2; p++) begin
         if (wr[p].en && (wr[p].addr != '0)) begin
            regs_d[wr[p].addr] = wr[p].data;
            busy_d[wr[p].addr] = 1'b0;
         end
      end
      if (iss_en && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign any_busy = |busy_q;

`ifdef REGFILE_BYPASS_EN
   logic [1:0]             wen;
   logic [1:0][ADDR_W-1:0] waddr;
   logic [1:0][DATA_W-1:0] wdata;

   assign wen   = {wr[1].en,   wr[0].en};
   assign waddr = {wr[1].addr, wr[0].addr};
   assign wdata = {wr[1].data, wr[0].data};
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_mp_sb_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH)
      ) u_rd (
         .regs_i     (regs_q),
         .busy_i     (busy_q),
         .addr_i     (rd_addr[k*ADDR_W +: ADDR_W]),
`ifdef REGFILE_BYPASS_EN
         .rst_ni     (rst_n),
         .wen_i      (wen),
         .waddr_i    (waddr),
         .wdata_i    (wdata),
         .iss_en_i   (iss_en),
         .iss_addr_i (iss_addr),
`endif
         .data_o     (rd_data[k*DATA_W +: DATA_W]),
         .busy_o     (rd_busy[k])
      );
   end

endmodule
